cus42_ram_sched: RTL

CUS42_RAM_SCHED -- requirements
Module: cus42_ram_sched

---
 rtl/cus42_ram_sched_if.sv | 25 ++
 rtl/cus42_ram_sched.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cus42_ram_sched_if.sv
// rtl/cus42_ram_sched_if.sv - CPU request/response bus for the tile RAM slot scheduler
//
// Purpose : groups the CPU-side handshake of cus42_ram_sched.
// Signals : cpu_req/cpu_we/cpu_addr[12:0]/cpu_wdata[7:0]  CPU -> scheduler
//           cpu_rdata[7:0]/cpu_ack/nWAIT                  scheduler -> CPU
// Modports: master = CPU side, slave = scheduler side.
interface cus42_ram_sched_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [12:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic        nWAIT;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, nWAIT
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, nWAIT
    );
endinterface

// File: rtl/cus42_ram_sched.sv
// rtl/cus42_ram_sched.sv - time-slot scheduler sharing one tile SRAM between two layers and a CPU
//
// Purpose : a 2-bit slot phase splits SRAM bandwidth 0=layer A, 1=CPU, 2=layer B, 3=CPU.
//           Layer slots fetch one byte each; CPU slots serve a single latched request.
//           A falling nHSYNC realigns the phase to 0.
// Option  : CUS42_BLANK_CPU_EN - when defined, every slot is a CPU slot while nHBLANK=0.
// Ports   : CLK_6M, nRST (sync, active-low)
//           nHSYNC, nHBLANK          video timing
//           RAA[11:0], RAB[11:0]     layer A/B tile addresses
//           cpu (slave modport)      CPU request/ack bus
//           RA[12:0], RD_I, RD_O, RD_OE, nRWE, nROE   SRAM pins (all registered)
//           TA_D/TA_VLD, TB_D/TB_VLD fetched layer bytes, VLD high one cycle
module cus42_ram_sched (
    input  logic             CLK_6M,
    input  logic             nRST,
    input  logic             nHSYNC,
    input  logic             nHBLANK,
    input  logic [11:0]      RAA,
    input  logic [11:0]      RAB,
    cus42_ram_sched_if.slave cpu,
    output logic [12:0]      RA,
    input  logic [7:0]       RD_I,
    output logic [7:0]       RD_O,
    output logic             RD_OE,
    output logic             nRWE,
    output logic             nROE,
    output logic [7:0]       TA_D,
    output logic             TA_VLD,
    output logic [7:0]       TB_D,
    output logic             TB_VLD
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [1:0]  r_ph;
    logic        r_hsync;
    logic        r_hsync_d;

    logic        r_we;
    logic [12:0] r_addr;
    logic [7:0]  r_wdata;
    logic [7:0]  r_rdata;

    logic [12:0] r_ra;
    logic [7:0]  r_rd_o;
    logic        r_rd_oe;
    logic        r_nrwe;
    logic        r_nroe;
    logic        r_fetch_a;
    logic        r_fetch_b;
    logic [7:0]  r_ta_d;
    logic        r_ta_vld;
    logic [7:0]  r_tb_d;
    logic        r_tb_vld;

    logic        w_hs_fall;
    logic [1:0]  w_ph_next;
    logic        w_blank;
    logic        w_slot_cpu;
    logic        w_slot_a;
    logic        w_slot_b;
    logic        w_access;
    logic        w_cpu_ack;
    logic        w_nwait;

`ifdef CUS42_BLANK_CPU_EN
    assign w_blank = ~nHBLANK;
`else
    logic w_unused;
    assign w_blank  = 1'b0;
    assign w_unused = nHBLANK;
`endif

    // Fall detected on the two registered copies, so the phase jump lands one
    // edge after the low level is first sampled.
    assign w_hs_fall = r_hsync_d & ~r_hsync;
    assign w_ph_next = w_hs_fall ? 2'd0 : r_ph + 2'd1;

    // Slot kind is decided for the phase being entered; outputs are registered
    // on that same edge so they are stable for the whole slot.
    assign w_slot_cpu = w_ph_next[0] | w_blank;
    assign w_slot_a   = ~w_slot_cpu & (w_ph_next == 2'd0);
    assign w_slot_b   = ~w_slot_cpu & (w_ph_next == 2'd2);
    assign w_access   = (r_state == ST_WAIT) & w_slot_cpu;

    always_comb begin
        w_state_next = r_state;
        w_cpu_ack    = 1'b0;
        w_nwait      = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (cpu.cpu_req) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_nwait = 1'b0;
                if (w_slot_cpu) begin
                    w_state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_nwait      = 1'b0;
                w_state_next = ST_DONE;
            end
            ST_DONE: begin
                // cpu_req is deliberately not looked at here.
                w_cpu_ack    = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_6M) begin
        if (!nRST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge CLK_6M) begin
        if (!nRST) begin
            r_ph      <= 2'd0;
            r_hsync   <= 1'b1;
            r_hsync_d <= 1'b1;
            r_we      <= 1'b0;
            r_addr    <= 13'd0;
            r_wdata   <= 8'd0;
            r_rdata   <= 8'd0;
            r_ra      <= 13'd0;
            r_rd_o    <= 8'd0;
            r_rd_oe   <= 1'b0;
            r_nrwe    <= 1'b1;
            r_nroe    <= 1'b1;
            r_fetch_a <= 1'b0;
            r_fetch_b <= 1'b0;
            r_ta_d    <= 8'd0;
            r_ta_vld  <= 1'b0;
            r_tb_d    <= 8'd0;
            r_tb_vld  <= 1'b0;
        end else begin
            r_ph      <= w_ph_next;
            r_hsync   <= nHSYNC;
            r_hsync_d <= r_hsync;

            // Request fields are frozen from acceptance until the FSM is idle again.
            if ((r_state == ST_IDLE) && cpu.cpu_req) begin
                r_we    <= cpu.cpu_we;
                r_addr  <= cpu.cpu_addr;
                r_wdata <= cpu.cpu_wdata;
            end

            // Default is an unused CPU slot: bus parked on layer A, no strobes.
            r_ra      <= {1'b0, RAA};
            r_rd_o    <= 8'd0;
            r_rd_oe   <= 1'b0;
            r_nrwe    <= 1'b1;
            r_nroe    <= 1'b1;
            r_fetch_a <= 1'b0;
            r_fetch_b <= 1'b0;

            if (w_access) begin
                r_ra <= r_addr;
                if (r_we) begin
                    r_rd_o  <= r_wdata;
                    r_rd_oe <= 1'b1;
                    r_nrwe  <= 1'b0;
                end else begin
                    r_nroe  <= 1'b0;
                end
            end else if (w_slot_a) begin
                r_nroe    <= 1'b0;
                r_fetch_a <= 1'b1;
            end else if (w_slot_b) begin
                r_ra      <= {1'b1, RAB};
                r_nroe    <= 1'b0;
                r_fetch_b <= 1'b1;
            end

            // Data read during a slot is captured on the edge that ends it.
            r_ta_vld <= r_fetch_a;
            if (r_fetch_a) begin
                r_ta_d <= RD_I;
            end
            r_tb_vld <= r_fetch_b;
            if (r_fetch_b) begin
                r_tb_d <= RD_I;
            end

            if ((r_state == ST_ACCESS) && !r_we) begin
                r_rdata <= RD_I;
            end
        end
    end

    assign RA            = r_ra;
    assign RD_O          = r_rd_o;
    assign RD_OE         = r_rd_oe;
    assign nRWE          = r_nrwe;
    assign nROE          = r_nroe;
    assign TA_D          = r_ta_d;
    assign TA_VLD        = r_ta_vld;
    assign TB_D          = r_tb_d;
    assign TB_VLD        = r_tb_vld;
    assign cpu.cpu_rdata = r_rdata;
    assign cpu.cpu_ack   = w_cpu_ack;
    assign cpu.nWAIT     = w_nwait;

endmodule
